// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC decode path:
// opcodes, instruction field map, stage state encoding.
package risc_pkg;

    localparam int INSTR_W_DEF = 16;
    localparam int PC_W_DEF    = 8;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_ILLO = 4'hA;
    localparam logic [3:0] OP_ILHI = 4'hE;
    localparam logic [3:0] OP_LIMM = 4'hF;

    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int RD_MSB   = 11;
    localparam int RD_LSB   = 9;
    localparam int RS1_MSB  = 8;
    localparam int RS1_LSB  = 6;
    localparam int RS2_MSB  = 5;
    localparam int RS2_LSB  = 3;
    localparam int IMM6_MSB = 5;
    localparam int IMM6_LSB = 0;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_WAIT_EXT = 2'd1,
        ST_FULL     = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [15:0] imm;
        logic        reg_we;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
        logic        illegal;
    } dec_t;

    function automatic logic [15:0] sext6(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational field split and control decode
// for one 16-bit instruction word.
module instr_decoder (
    input  logic [15:0] instr,
    output logic [3:0]  opcode,
    output logic [2:0]  rd,
    output logic [2:0]  rs1,
    output logic [2:0]  rs2,
    output logic [15:0] imm16,
    output logic        reg_we,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        branch,
    output logic        illegal
);
    import risc_pkg::*;

    logic [3:0] opc;
    logic       is_alu;
    logic       is_ld;
    logic       is_st;
    logic       is_br;
    logic       is_limm;
    logic       is_ill;

    assign opc     = instr[OPC_MSB:OPC_LSB];
    assign is_alu  = opc inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI};
    assign is_ld   = (opc == OP_LD);
    assign is_st   = (opc == OP_ST);
    assign is_br   = opc inside {OP_BEQ, OP_JMP};
    assign is_limm = (opc == OP_LIMM);
    assign is_ill  = (opc >= OP_ILLO) && (opc <= OP_ILHI);

    // Decode: fields pass through; LIMM clears rs/imm since
    // its immediate arrives in the following word.
    always_comb begin
        opcode  = opc;
        rd      = instr[RD_MSB:RD_LSB];
        rs1     = instr[RS1_MSB:RS1_LSB];
        rs2     = instr[RS2_MSB:RS2_LSB];
        imm16   = sext6(instr[IMM6_MSB:IMM6_LSB]);
        reg_we  = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        branch  = 1'b0;
        illegal = 1'b0;
        unique case (1'b1)
            is_alu: reg_we = 1'b1;
            is_ld: begin
                reg_we = 1'b1;
                mem_rd = 1'b1;
            end
            is_st:  mem_wr = 1'b1;
            is_br:  branch = 1'b1;
            is_limm: begin
                reg_we = 1'b1;
                rs1    = 3'd0;
                rs2    = 3'd0;
                imm16  = 16'h0000;
            end
            is_ill: illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: single-entry output register,
// valid/ready on both sides, two-beat LIMM assembly.
module decode_stage #(
    parameter int INSTR_W = risc_pkg::INSTR_W_DEF,
    parameter int PC_W    = risc_pkg::PC_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_opcode,
    output logic [2:0]         out_rd,
    output logic [2:0]         out_rs1,
    output logic [2:0]         out_rs2,
    output logic [15:0]        out_imm,
    output logic [PC_W-1:0]    out_pc,
    output logic               out_reg_we,
    output logic               out_mem_rd,
    output logic               out_mem_wr,
    output logic               out_branch,
    output logic               out_illegal
);
    import risc_pkg::*;

    state_t          state;
    state_t          state_nxt;
    dec_t            dec;
    dec_t            q;
    logic [PC_W-1:0] pc_q;
    logic            accept;
    logic            is_limm;

    instr_decoder u_dec (
        .instr   (in_instr[15:0]),
        .opcode  (dec.opcode),
        .rd      (dec.rd),
        .rs1     (dec.rs1),
        .rs2     (dec.rs2),
        .imm16   (dec.imm),
        .reg_we  (dec.reg_we),
        .mem_rd  (dec.mem_rd),
        .mem_wr  (dec.mem_wr),
        .branch  (dec.branch),
        .illegal (dec.illegal)
    );

    assign is_limm  = (dec.opcode == OP_LIMM);
    assign in_ready = rst && !flush &&
                      ((state != ST_FULL) || out_ready);
    assign accept   = in_valid && in_ready;

    // Next state: flush wins, otherwise follow the handshake.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept)
                        state_nxt = is_limm ? ST_WAIT_EXT
                                            : ST_FULL;
                end
                ST_WAIT_EXT: begin
                    if (accept)
                        state_nxt = ST_FULL;
                end
                ST_FULL: begin
                    if (out_ready) begin
                        if (accept)
                            state_nxt = is_limm ? ST_WAIT_EXT
                                                : ST_FULL;
                        else
                            state_nxt = ST_EMPTY;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_EMPTY;
        else
            state <= state_nxt;
    end

    // Output register: first beat loads the decode, the
    // extension beat only fills the immediate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q    <= '0;
            pc_q <= '0;
        end else if (accept) begin
            if (state == ST_WAIT_EXT) begin
                q.imm <= in_instr[15:0];
            end else begin
                q    <= dec;
                pc_q <= in_pc;
            end
        end
    end

    assign out_valid   = (state == ST_FULL);
    assign out_opcode  = q.opcode;
    assign out_rd      = q.rd;
    assign out_rs1     = q.rs1;
    assign out_rs2     = q.rs2;
    assign out_imm     = q.imm;
    assign out_pc      = pc_q;
    assign out_reg_we  = q.reg_we;
    assign out_mem_rd  = q.mem_rd;
    assign out_mem_wr  = q.mem_wr;
    assign out_branch  = q.branch;
    assign out_illegal = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: vector table plus
// streaming, LIMM, backpressure, flush and reset sequences.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [7:0]  in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_opcode;
    logic [2:0]  out_rd;
    logic [2:0]  out_rs1;
    logic [2:0]  out_rs2;
    logic [15:0] out_imm;
    logic [7:0]  out_pc;
    logic        out_reg_we;
    logic        out_mem_rd;
    logic        out_mem_wr;
    logic        out_branch;
    logic        out_illegal;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decode_stage #(.INSTR_W(16), .PC_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_imm     (out_imm),
        .out_pc      (out_pc),
        .out_reg_we  (out_reg_we),
        .out_mem_rd  (out_mem_rd),
        .out_mem_wr  (out_mem_wr),
        .out_branch  (out_branch),
        .out_illegal (out_illegal)
    );

    // flags = {reg_we, mem_rd, mem_wr, branch, illegal}
    typedef struct {
        logic [15:0] instr;
        logic [7:0]  pc;
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [15:0] imm;
        logic [4:0]  fl;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [63:0] snap();
        return {21'b0, out_valid, out_opcode, out_rd, out_rs1,
                out_rs2, out_imm, out_pc, out_reg_we, out_mem_rd,
                out_mem_wr, out_branch, out_illegal};
    endfunction

    function automatic logic [63:0] mk(
        input logic        v,
        input logic [3:0]  op,
        input logic [2:0]  rd,
        input logic [2:0]  rs1,
        input logic [2:0]  rs2,
        input logic [15:0] imm,
        input logic [7:0]  pc,
        input logic [4:0]  fl
    );
        return {21'b0, v, op, rd, rs1, rs2, imm, pc, fl};
    endfunction

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h",
                     name, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] instr,
                        input logic [7:0] pc);
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{16'h1298, 8'h04, 4'h1, 3'd1, 3'd2, 3'd3,
                     16'h0018, 5'b10000};
        vecs[1]  = '{16'h547F, 8'h06, 4'h5, 3'd2, 3'd1, 3'd7,
                     16'hFFFF, 5'b10000};
        vecs[2]  = '{16'h6000, 8'h08, 4'h6, 3'd0, 3'd0, 3'd0,
                     16'h0000, 5'b11000};
        vecs[3]  = '{16'hA000, 8'h0A, 4'hA, 3'd0, 3'd0, 3'd0,
                     16'h0000, 5'b00001};
        vecs[4]  = '{16'h7000, 8'h0C, 4'h7, 3'd0, 3'd0, 3'd0,
                     16'h0000, 5'b00100};
        vecs[5]  = '{16'h8000, 8'h0E, 4'h8, 3'd0, 3'd0, 3'd0,
                     16'h0000, 5'b00010};
        vecs[6]  = '{16'h9ABC, 8'h10, 4'h9, 3'd5, 3'd2, 3'd7,
                     16'hFFFC, 5'b00010};
        vecs[7]  = '{16'h0000, 8'h12, 4'h0, 3'd0, 3'd0, 3'd0,
                     16'h0000, 5'b00000};
        vecs[8]  = '{16'h2E51, 8'h14, 4'h2, 3'd7, 3'd1, 3'd2,
                     16'h0011, 5'b10000};
        vecs[9]  = '{16'h3FFF, 8'h16, 4'h3, 3'd7, 3'd7, 3'd7,
                     16'hFFFF, 5'b10000};
        vecs[10] = '{16'hE123, 8'h18, 4'hE, 3'd0, 3'd4, 3'd4,
                     16'hFFE3, 5'b00001};
        vecs[11] = '{16'h4020, 8'h1A, 4'h4, 3'd0, 3'd0, 3'd4,
                     16'hFFE0, 5'b10000};

        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 16'h0000;
        in_pc     = 8'h00;
        out_ready = 1'b1;

        // reset state
        #3;
        chk("reset_outputs", snap(), 64'h0);
        chk("reset_in_ready", in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("idle_in_ready", in_ready, 1'b1);

        // vector table, one instruction at a time
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].instr, vecs[i].pc);
            chk($sformatf("vec%0d_%h", i, vecs[i].instr), snap(),
                mk(1'b1, vecs[i].op, vecs[i].rd, vecs[i].rs1,
                   vecs[i].rs2, vecs[i].imm, vecs[i].pc,
                   vecs[i].fl));
        end

        // back-to-back stream including a LIMM from FULL
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = 16'h1298;
        in_pc    = 8'h40;
        @(negedge clk);
        chk("stream_add", snap(),
            mk(1'b1, 4'h1, 3'd1, 3'd2, 3'd3, 16'h0018, 8'h40,
               5'b10000));
        in_instr = 16'hF600;
        in_pc    = 8'h41;
        @(negedge clk);
        chk("limm_beat1_valid", out_valid, 1'b0);
        in_instr = 16'hBEEF;
        in_pc    = 8'h42;
        @(negedge clk);
        chk("limm_full", snap(),
            mk(1'b1, 4'hF, 3'd3, 3'd0, 3'd0, 16'hBEEF, 8'h41,
               5'b10000));
        in_instr = 16'h6000;
        in_pc    = 8'h43;
        @(negedge clk);
        chk("stream_ld", snap(),
            mk(1'b1, 4'h6, 3'd0, 3'd0, 3'd0, 16'h0000, 8'h43,
               5'b11000));
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_drain", out_valid, 1'b0);

        // backpressure while FULL
        out_ready = 1'b0;
        send(16'h1298, 8'h20);
        in_valid = 1'b1;
        in_instr = 16'h547F;
        in_pc    = 8'h21;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp_in_ready%0d", k), in_ready, 1'b0);
            chk($sformatf("bp_hold%0d", k), snap(),
                mk(1'b1, 4'h1, 3'd1, 3'd2, 3'd3, 16'h0018, 8'h20,
                   5'b10000));
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_queued", snap(),
            mk(1'b1, 4'h5, 3'd2, 3'd1, 3'd7, 16'hFFFF, 8'h21,
               5'b10000));
        @(negedge clk);
        chk("bp_drain", out_valid, 1'b0);

        // flush during WAIT_EXT discards the partial LIMM
        send(16'hF600, 8'h30);
        chk("wait_ext_valid", out_valid, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 16'h8000;
        in_pc    = 8'h31;
        #1;
        chk("flush_in_ready", in_ready, 1'b0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", out_valid, 1'b0);
        send(16'h8000, 8'h32);
        chk("post_flush_beq", snap(),
            mk(1'b1, 4'h8, 3'd0, 3'd0, 3'd0, 16'h0000, 8'h32,
               5'b00010));

        // flush while FULL and stalled
        out_ready = 1'b0;
        send(16'h1298, 8'h50);
        chk("full_before_flush", out_valid, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_full_valid", out_valid, 1'b0);

        // asynchronous reset while FULL
        send(16'h3FFF, 8'h60);
        chk("full_before_rst", out_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_outputs", snap(), 64'h0);
        chk("async_rst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("after_rst_valid", out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
